// File: rtl/axi4_lite_if_pkg.sv
// Shared AXI4-Lite types: the response encoding used by every AXI4-Lite block.
package axi4_lite_if_pkg;

  typedef logic [1:0] axi4_resp_t;

  localparam axi4_resp_t AXI4_RESP_OKAY   = 2'b00;
  localparam axi4_resp_t AXI4_RESP_EXOKAY = 2'b01;
  localparam axi4_resp_t AXI4_RESP_SLVERR = 2'b10;
  localparam axi4_resp_t AXI4_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_reg_bank_slv_pkg.sv
// Register-bank helpers. Build option AXI4_LITE_REG_BANK_SLV_DECERR_EN selects
// whether out-of-range accesses answer DECERR (defined) or OKAY (undefined).
package axi4_lite_reg_bank_slv_pkg;
  import axi4_lite_if_pkg::*;

  // Response for an access, given whether it decoded to an existing register.
  function automatic axi4_resp_t range_resp(input logic in_range);
`ifdef AXI4_LITE_REG_BANK_SLV_DECERR_EN
    return in_range ? AXI4_RESP_OKAY : AXI4_RESP_DECERR;
`else
    return AXI4_RESP_OKAY;
`endif
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle with requester (mst_port) and responder (slv_port) views.
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid and ready are both high; once valid is raised, the source keeps
// valid and its payload unchanged until that transfer; ready may be driven
// independently of valid.
interface axi4_lite_if
#(
  parameter int AXI4_LITE_ADDR_BIT_WIDTH = 32,
  parameter int AXI4_LITE_DATA_BIT_WIDTH = 32
);
  import axi4_lite_if_pkg::*;

  logic                                  awvalid;
  logic                                  awready;
  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   awaddr;
  logic [2:0]                            awprot;
  logic                                  wvalid;
  logic                                  wready;
  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   wdata;
  logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0] wstrb;
  logic                                  bvalid;
  logic                                  bready;
  axi4_resp_t                            bresp;
  logic                                  arvalid;
  logic                                  arready;
  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   araddr;
  logic [2:0]                            arprot;
  logic                                  rvalid;
  logic                                  rready;
  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   rdata;
  axi4_resp_t                            rresp;

  modport slv_port (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport mst_port (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi4_lite_1deep_buf.sv
// One-entry holding buffer between an upstream and a downstream valid/ready
// pair. It never accepts and releases in the same cycle, so up_ready depends
// only on the fill state (and reset), never on dn_ready.
module axi4_lite_1deep_buf
#(
  parameter int PAYLOAD_WIDTH = 32
)
(
  input  logic                     i_clk,
  input  logic                     i_sync_rst,
  input  logic                     up_valid,
  output logic                     up_ready,
  input  logic [PAYLOAD_WIDTH-1:0] up_data,
  output logic                     dn_valid,
  input  logic                     dn_ready,
  output logic [PAYLOAD_WIDTH-1:0] dn_data
);

  logic                     full;
  logic [PAYLOAD_WIDTH-1:0] data_q;

  assign up_ready = ~full & ~i_sync_rst;
  assign dn_valid = full;
  assign dn_data  = data_q;

  // Fill on an upstream transfer, empty on a downstream transfer.
  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      full   <= 1'b0;
      data_q <= '0;
    end else if (up_valid && up_ready) begin
      full   <= 1'b1;
      data_q <= up_data;
    end else if (dn_valid && dn_ready) begin
      full   <= 1'b0;
    end
  end

endmodule

// File: rtl/axi4_lite_reg_bank_slv.sv
// AXI4-Lite register bank: NUM_REGS 32-bit registers with byte-strobed writes,
// registered single-cycle reads and a per-register write pulse.
// Build option AXI4_LITE_REG_BANK_SLV_DECERR_EN: DECERR for out-of-range access.
module axi4_lite_reg_bank_slv
  import axi4_lite_if_pkg::*;
  import axi4_lite_reg_bank_slv_pkg::*;
#(
  parameter int AXI4_LITE_ADDR_BIT_WIDTH = 32,
  parameter int AXI4_LITE_DATA_BIT_WIDTH = 32,
  parameter int NUM_REGS                 = 4
)
(
  input  logic                                               i_clk,
  input  logic                                               i_sync_rst,
  axi4_lite_if.slv_port                                      if_s_axi4_lite,
  output logic [NUM_REGS-1:0][AXI4_LITE_DATA_BIT_WIDTH-1:0]  o_regs,
  output logic [NUM_REGS-1:0]                                o_wr_pulse
);

  localparam int IDX_W   = $clog2(NUM_REGS);
  localparam int DATA_W  = AXI4_LITE_DATA_BIT_WIDTH;
  localparam int ADDR_W  = AXI4_LITE_ADDR_BIT_WIDTH;
  localparam int STRB_W  = DATA_W / 8;
  localparam int W_PAY_W = DATA_W + STRB_W;

  // ---------------- write path ----------------
  logic                aw_full;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic                w_full;
  logic [W_PAY_W-1:0]  w_pay_q;
  logic                commit;
  logic                bvalid_q;
  axi4_resp_t          bresp_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [IDX_W-1:0]    wr_idx;
  logic                wr_in_range;
  logic [DATA_W-1:0]   wr_merged;

  axi4_lite_1deep_buf #(.PAYLOAD_WIDTH(ADDR_W)) u_aw_buf (
    .i_clk      (i_clk),
    .i_sync_rst (i_sync_rst),
    .up_valid   (if_s_axi4_lite.awvalid),
    .up_ready   (if_s_axi4_lite.awready),
    .up_data    (if_s_axi4_lite.awaddr),
    .dn_valid   (aw_full),
    .dn_ready   (commit),
    .dn_data    (aw_addr_q)
  );

  axi4_lite_1deep_buf #(.PAYLOAD_WIDTH(W_PAY_W)) u_w_buf (
    .i_clk      (i_clk),
    .i_sync_rst (i_sync_rst),
    .up_valid   (if_s_axi4_lite.wvalid),
    .up_ready   (if_s_axi4_lite.wready),
    .up_data    ({if_s_axi4_lite.wstrb, if_s_axi4_lite.wdata}),
    .dn_valid   (w_full),
    .dn_ready   (commit),
    .dn_data    (w_pay_q)
  );

  // A write commits once address and data are both held and no B is pending.
  assign commit      = aw_full & w_full & ~bvalid_q;
  assign wdata_q     = w_pay_q[DATA_W-1:0];
  assign wstrb_q     = w_pay_q[W_PAY_W-1:DATA_W];
  assign wr_idx      = aw_addr_q[IDX_W+1:2];
  assign wr_in_range = (aw_addr_q >> (IDX_W + 2)) == '0;

  // Merge the enabled byte lanes of the write data into the current contents.
  always_comb begin
    wr_merged = o_regs[wr_idx];
    for (int b = 0; b < STRB_W; b++) begin
      if (wstrb_q[b]) wr_merged[b*8 +: 8] = wdata_q[b*8 +: 8];
    end
  end

  // Register update, write pulse and B channel response.
  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      o_regs     <= '0;
      o_wr_pulse <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= AXI4_RESP_OKAY;
    end else begin
      o_wr_pulse <= '0;
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= range_resp(wr_in_range);
        if (wr_in_range) begin
          o_regs[wr_idx]     <= wr_merged;
          o_wr_pulse[wr_idx] <= 1'b1;
        end
      end else if (bvalid_q && if_s_axi4_lite.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  assign if_s_axi4_lite.bvalid = bvalid_q;
  assign if_s_axi4_lite.bresp  = bresp_q;

  // ---------------- read path ----------------
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  axi4_resp_t        rresp_q;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_in_range;

  assign rd_idx      = if_s_axi4_lite.araddr[IDX_W+1:2];
  assign rd_in_range = (if_s_axi4_lite.araddr >> (IDX_W + 2)) == '0;

  assign if_s_axi4_lite.arready = ~rvalid_q & ~i_sync_rst;

  // Capture read data on AR transfer; o_regs still holds the pre-write value
  // when a commit to the same register lands on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= AXI4_RESP_OKAY;
    end else if (if_s_axi4_lite.arvalid && if_s_axi4_lite.arready) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_in_range ? o_regs[rd_idx] : '0;
      rresp_q  <= range_resp(rd_in_range);
    end else if (rvalid_q && if_s_axi4_lite.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign if_s_axi4_lite.rvalid = rvalid_q;
  assign if_s_axi4_lite.rdata  = rdata_q;
  assign if_s_axi4_lite.rresp  = rresp_q;

  // Protection bits carry no meaning for this bank.
  logic unused_prot;
  assign unused_prot = ^{if_s_axi4_lite.awprot, if_s_axi4_lite.arprot};

endmodule

// File: tb/tb_axi4_lite_reg_bank_slv.sv
// Directed testbench for axi4_lite_reg_bank_slv (4 registers, 32-bit bus).
module tb_axi4_lite_reg_bank_slv;
  import axi4_lite_if_pkg::*;

  localparam int A = 32;
  localparam int D = 32;
  localparam int N = 4;

`ifdef AXI4_LITE_REG_BANK_SLV_DECERR_EN
  localparam axi4_resp_t OOR_RESP = AXI4_RESP_DECERR;
`else
  localparam axi4_resp_t OOR_RESP = AXI4_RESP_OKAY;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_lite_if #(.AXI4_LITE_ADDR_BIT_WIDTH(A), .AXI4_LITE_DATA_BIT_WIDTH(D)) axi_if ();

  logic [N-1:0][D-1:0] regs;
  logic [N-1:0]        wr_pulse;

  axi4_lite_reg_bank_slv #(
    .AXI4_LITE_ADDR_BIT_WIDTH (A),
    .AXI4_LITE_DATA_BIT_WIDTH (D),
    .NUM_REGS                 (N)
  ) dut (
    .i_clk          (clk),
    .i_sync_rst     (rst),
    .if_s_axi4_lite (axi_if),
    .o_regs         (regs),
    .o_wr_pulse     (wr_pulse)
  );

  // ---------------- scoreboard state ----------------
  int            chk_cnt  = 0;
  int            pass_cnt = 0;
  logic [D-1:0]  model [N];
  logic [N-1:0]  pulse_q[$];

  // Record every cycle with a write pulse, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (wr_pulse != '0) pulse_q.push_back(wr_pulse);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [A-1:0] addr, input logic [D-1:0] data,
                           input logic [3:0] strb, output axi4_resp_t resp);
    bit aw_done = 0;
    bit w_done  = 0;
    bit aw_hs, w_hs;
    int cyc = 0;
    @(negedge clk);
    axi_if.awvalid = 1'b1; axi_if.awaddr = addr; axi_if.awprot = 3'b000;
    axi_if.wvalid  = 1'b1; axi_if.wdata  = data; axi_if.wstrb  = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      aw_hs = axi_if.awvalid && axi_if.awready;
      w_hs  = axi_if.wvalid && axi_if.wready;
      @(negedge clk); cyc++;
      if (aw_hs) begin axi_if.awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin axi_if.wvalid  = 1'b0; w_done  = 1; end
    end
    axi_if.awvalid = 1'b0; axi_if.wvalid = 1'b0;
    while (!axi_if.bvalid && cyc < 50) begin @(negedge clk); cyc++; end
    if (!axi_if.bvalid) begin
      chk_cnt++;
      $display("FAIL write_timeout addr=%h: no bvalid within 50 cycles", addr);
    end
    resp = axi_if.bresp;
  endtask

  task automatic axi_read(input logic [A-1:0] addr, output logic [D-1:0] data,
                          output axi4_resp_t resp);
    bit hs = 0;
    int cyc = 0;
    @(negedge clk);
    axi_if.arvalid = 1'b1; axi_if.araddr = addr; axi_if.arprot = 3'b000;
    while (!hs && cyc < 50) begin
      hs = axi_if.arvalid && axi_if.arready;
      @(negedge clk); cyc++;
    end
    axi_if.arvalid = 1'b0;
    while (!axi_if.rvalid && cyc < 50) begin @(negedge clk); cyc++; end
    if (!axi_if.rvalid) begin
      chk_cnt++;
      $display("FAIL read_timeout addr=%h: no rvalid within 50 cycles", addr);
    end
    data = axi_if.rdata;
    resp = axi_if.rresp;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [D-1:0] rd; axi4_resp_t rs;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk_cnt++;
    if ({axi_if.awready, axi_if.wready, axi_if.arready} !== 3'b000)
      $display("FAIL rst_readies: got %b expected 000", {axi_if.awready, axi_if.wready, axi_if.arready});
    else pass_cnt++;
    chk_cnt++;
    if ({axi_if.bvalid, axi_if.rvalid, axi_if.bresp, axi_if.rresp, axi_if.rdata} !== '0)
      $display("FAIL rst_resp_state: bvalid=%b rvalid=%b rdata=%h expected all 0", axi_if.bvalid, axi_if.rvalid, axi_if.rdata);
    else pass_cnt++;
    chk_cnt++;
    if (regs !== '0 || wr_pulse !== '0)
      $display("FAIL rst_regs: regs=%h pulse=%b expected 0", regs, wr_pulse);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({axi_if.awready, axi_if.wready, axi_if.arready} !== 3'b111)
      $display("FAIL rst_release_readies: got %b expected 111", {axi_if.awready, axi_if.wready, axi_if.arready});
    else pass_cnt++;
    for (int i = 0; i < N; i++) begin
      axi_read(32'(i * 4), rd, rs);
      chk_cnt++;
      if (rd !== 32'h0) $display("FAIL rst_read_data[%0d]: got %h expected 00000000", i, rd);
      else pass_cnt++;
      chk_cnt++;
      if (rs !== AXI4_RESP_OKAY) $display("FAIL rst_read_resp[%0d]: got %b expected 00", i, rs);
      else pass_cnt++;
    end
    for (int i = 0; i < N; i++) model[i] = '0;
  endtask

  task automatic test_write_read();
    logic [D-1:0] vals [N];
    logic [D-1:0] rd; axi4_resp_t rs; logic [N-1:0] obs_p;
    vals = '{32'h12345678, 32'h87654321, 32'hABCDEF01, 32'h10FEDCBA};
    for (int i = 0; i < N; i++) begin
      pulse_q.delete();
      axi_write(32'(i * 4), vals[i], 4'hF, rs);
      model[i] = vals[i];
      chk_cnt++;
      if (rs !== AXI4_RESP_OKAY) $display("FAIL wr_bresp[%0d]: got %b expected 00", i, rs);
      else pass_cnt++;
      obs_p = (pulse_q.size() == 1) ? pulse_q[0] : 'x;
      chk_cnt++;
      if (obs_p !== 4'(1 << i)) $display("FAIL wr_pulse[%0d]: got %b (%0d pulse cycles) expected %b", i, obs_p, pulse_q.size(), 4'(1 << i));
      else pass_cnt++;
      chk_cnt++;
      if (regs[i] !== model[i]) $display("FAIL wr_regs[%0d]: got %h expected %h", i, regs[i], model[i]);
      else pass_cnt++;
    end
    for (int i = 0; i < N; i++) begin
      axi_read(32'(i * 4), rd, rs);
      chk_cnt++;
      if (rd !== vals[i]) $display("FAIL wr_readback[%0d]: got %h expected %h", i, rd, vals[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_strobes();
    logic [D-1:0] rd; axi4_resp_t rs; logic [N-1:0] obs_p;
    axi_write(32'h4, 32'hFFFFFFFF, 4'hF, rs);
    pulse_q.delete();
    axi_write(32'h4, 32'h00000000, 4'h5, rs);
    model[1] = 32'hFF00FF00;
    obs_p = (pulse_q.size() == 1) ? pulse_q[0] : 'x;
    chk_cnt++;
    if (obs_p !== 4'b0010) $display("FAIL strb_pulse: got %b expected 0010", obs_p);
    else pass_cnt++;
    axi_read(32'h4, rd, rs);
    chk_cnt++;
    if (rd !== 32'hFF00FF00) $display("FAIL strb_readback: got %h expected ff00ff00", rd);
    else pass_cnt++;
    // Zero strobe: contents unchanged but the pulse still fires.
    pulse_q.delete();
    axi_write(32'hC, 32'h55555555, 4'h0, rs);
    obs_p = (pulse_q.size() == 1) ? pulse_q[0] : 'x;
    chk_cnt++;
    if (obs_p !== 4'b1000) $display("FAIL strb0_pulse: got %b expected 1000", obs_p);
    else pass_cnt++;
    chk_cnt++;
    if (regs[3] !== 32'h10FEDCBA) $display("FAIL strb0_regs: got %h expected 10fedcba", regs[3]);
    else pass_cnt++;
  endtask

  task automatic test_w_before_aw();
    logic [N-1:0] obs_p;
    pulse_q.delete();
    @(negedge clk);
    axi_if.wvalid = 1'b1; axi_if.wdata = 32'h0BADF00D; axi_if.wstrb = 4'hF;
    @(negedge clk);
    axi_if.wvalid = 1'b0;
    chk_cnt++;
    if ({axi_if.wready, axi_if.bvalid} !== 2'b00) $display("FAIL wfirst_held: wready,bvalid=%b expected 00", {axi_if.wready, axi_if.bvalid});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    axi_if.awvalid = 1'b1; axi_if.awaddr = 32'h8;
    @(negedge clk);
    axi_if.awvalid = 1'b0;
    chk_cnt++;
    if ({axi_if.awready, axi_if.bvalid} !== 2'b00) $display("FAIL wfirst_aw_taken: awready,bvalid=%b expected 00", {axi_if.awready, axi_if.bvalid});
    else pass_cnt++;
    @(negedge clk);
    model[2] = 32'h0BADF00D;
    chk_cnt++;
    if ({axi_if.bvalid, axi_if.bresp} !== {1'b1, AXI4_RESP_OKAY}) $display("FAIL wfirst_bvalid: bvalid,bresp=%b expected 100", {axi_if.bvalid, axi_if.bresp});
    else pass_cnt++;
    chk_cnt++;
    if (regs[2] !== 32'h0BADF00D) $display("FAIL wfirst_regs: got %h expected 0badf00d", regs[2]);
    else pass_cnt++;
    @(negedge clk);
    obs_p = (pulse_q.size() == 1) ? pulse_q[0] : 'x;
    chk_cnt++;
    if ({axi_if.bvalid, obs_p} !== 5'b0_0100) $display("FAIL wfirst_single_commit: bvalid=%b pulse=%b expected 0 0100", axi_if.bvalid, obs_p);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [N-1:0] obs_p;
    logic [44:0]  obs_v;
    @(negedge clk);
    pulse_q.delete();
    axi_if.bready = 1'b0; axi_if.rready = 1'b0;
    axi_if.awvalid = 1'b1; axi_if.awaddr = 32'h0; axi_if.wvalid = 1'b1;
    axi_if.wdata = 32'hCAFEF00D; axi_if.wstrb = 4'hF;
    axi_if.arvalid = 1'b1; axi_if.araddr = 32'hC;
    @(negedge clk);
    axi_if.awvalid = 1'b0; axi_if.wvalid = 1'b0; axi_if.arvalid = 1'b0;
    @(negedge clk);
    axi_if.awvalid = 1'b1; axi_if.awaddr = 32'h4; axi_if.wvalid = 1'b1;
    axi_if.wdata = 32'h11111111; axi_if.wstrb = 4'hF;
    @(negedge clk);
    axi_if.awvalid = 1'b0; axi_if.wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      obs_v = {axi_if.bvalid, axi_if.bresp, axi_if.rvalid, axi_if.rresp, axi_if.rdata,
               axi_if.awready, axi_if.wready, axi_if.arready};
      chk_cnt++;
      if (obs_v !== {1'b1, AXI4_RESP_OKAY, 1'b1, AXI4_RESP_OKAY, 32'h10FEDCBA, 3'b000})
        $display("FAIL bp_stable[%0d]: got %h expected %h", i, obs_v, {1'b1, AXI4_RESP_OKAY, 1'b1, AXI4_RESP_OKAY, 32'h10FEDCBA, 3'b000});
      else pass_cnt++;
      @(negedge clk);
    end
    chk_cnt++;
    if ({regs[1], regs[0]} !== {32'hFF00FF00, 32'hCAFEF00D}) $display("FAIL bp_regs_hold: got %h %h expected ff00ff00 cafef00d", regs[1], regs[0]);
    else pass_cnt++;
    axi_if.bready = 1'b1; axi_if.rready = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if ({axi_if.bvalid, axi_if.rvalid, axi_if.arready} !== 3'b001) $display("FAIL bp_release: bvalid,rvalid,arready=%b expected 001", {axi_if.bvalid, axi_if.rvalid, axi_if.arready});
    else pass_cnt++;
    @(negedge clk);
    model[0] = 32'hCAFEF00D; model[1] = 32'h11111111;
    chk_cnt++;
    if ({axi_if.bvalid, regs[1]} !== {1'b1, 32'h11111111}) $display("FAIL bp_second_commit: bvalid=%b reg1=%h expected 1 11111111", axi_if.bvalid, regs[1]);
    else pass_cnt++;
    @(negedge clk);
    obs_p = 'x;
    chk_cnt++;
    if (pulse_q.size() != 2) $display("FAIL bp_pulses: got %0d pulse cycles expected 2", pulse_q.size());
    else if ({pulse_q[1], pulse_q[0]} !== 8'b0010_0001) $display("FAIL bp_pulses: got %b %b expected 0010 0001", pulse_q[1], pulse_q[0]);
    else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    logic [D-1:0] rd; axi4_resp_t rs;
    pulse_q.delete();
    axi_write(32'h10, 32'hDEADBEEF, 4'hF, rs);
    chk_cnt++;
    if (rs !== OOR_RESP) $display("FAIL oor_bresp: got %b expected %b", rs, OOR_RESP);
    else pass_cnt++;
    chk_cnt++;
    if (regs !== {model[3], model[2], model[1], model[0]}) $display("FAIL oor_regs: got %h expected %h", regs, {model[3], model[2], model[1], model[0]});
    else pass_cnt++;
    chk_cnt++;
    if (pulse_q.size() != 0) $display("FAIL oor_pulse: got %0d pulse cycles expected 0", pulse_q.size());
    else pass_cnt++;
    axi_read(32'h10, rd, rs);
    chk_cnt++;
    if (rd !== 32'h0) $display("FAIL oor_rdata: got %h expected 00000000", rd);
    else pass_cnt++;
    chk_cnt++;
    if (rs !== OOR_RESP) $display("FAIL oor_rresp: got %b expected %b", rs, OOR_RESP);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    logic [D-1:0] rd; axi4_resp_t rs;
    @(negedge clk);
    axi_if.awvalid = 1'b1; axi_if.awaddr = 32'h8; axi_if.wvalid = 1'b1;
    axi_if.wdata = 32'h5A5A5A5A; axi_if.wstrb = 4'hF;
    @(negedge clk);
    axi_if.awvalid = 1'b0; axi_if.wvalid = 1'b0;
    axi_if.arvalid = 1'b1; axi_if.araddr = 32'h8;
    @(negedge clk);
    axi_if.arvalid = 1'b0;
    chk_cnt++;
    if ({axi_if.rvalid, axi_if.rdata} !== {1'b1, 32'h0BADF00D}) $display("FAIL coll_old_value: rvalid=%b rdata=%h expected 1 0badf00d", axi_if.rvalid, axi_if.rdata);
    else pass_cnt++;
    chk_cnt++;
    if ({axi_if.bvalid, regs[2]} !== {1'b1, 32'h5A5A5A5A}) $display("FAIL coll_commit: bvalid=%b reg2=%h expected 1 5a5a5a5a", axi_if.bvalid, regs[2]);
    else pass_cnt++;
    model[2] = 32'h5A5A5A5A;
    axi_read(32'h8, rd, rs);
    chk_cnt++;
    if (rd !== 32'h5A5A5A5A) $display("FAIL coll_new_value: got %h expected 5a5a5a5a", rd);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [D-1:0] wv [N];
    int item = 0; int b_cnt = 0; int r_cnt = 0; int cyc = 0; bit hs;
    wv = '{32'h11110000, 32'h22220001, 32'h33330002, 32'h44440003};
    @(negedge clk);
    pulse_q.delete();
    axi_if.awvalid = 1'b1; axi_if.awaddr = 32'h0; axi_if.wvalid = 1'b1;
    axi_if.wdata = wv[0]; axi_if.wstrb = 4'hF;
    while (b_cnt < 4 && cyc < 40) begin
      hs = axi_if.awvalid && axi_if.awready && axi_if.wvalid && axi_if.wready;
      @(negedge clk); cyc++;
      if (hs) begin
        item++;
        if (item < 4) begin axi_if.awaddr = 32'(item * 4); axi_if.wdata = wv[item]; end
        else begin axi_if.awvalid = 1'b0; axi_if.wvalid = 1'b0; end
      end
      if (axi_if.bvalid) b_cnt++;
    end
    axi_if.awvalid = 1'b0; axi_if.wvalid = 1'b0;
    for (int i = 0; i < N; i++) model[i] = wv[i];
    chk_cnt++;
    if (b_cnt != 4 || cyc != 8) $display("FAIL b2b_write_cycles: %0d responses in %0d cycles expected 4 in 8", b_cnt, cyc);
    else pass_cnt++;
    chk_cnt++;
    if (pulse_q.size() != 4) $display("FAIL b2b_pulses: got %0d pulse cycles expected 4", pulse_q.size());
    else if ({pulse_q[3], pulse_q[2], pulse_q[1], pulse_q[0]} !== 16'h8421) $display("FAIL b2b_pulses: got %h expected 8421", {pulse_q[3], pulse_q[2], pulse_q[1], pulse_q[0]});
    else pass_cnt++;
    // Reads of the four fresh values with arvalid held high.
    item = 0; cyc = 0;
    @(negedge clk);
    axi_if.arvalid = 1'b1; axi_if.araddr = 32'h0;
    while (r_cnt < 4 && cyc < 40) begin
      hs = axi_if.arvalid && axi_if.arready;
      @(negedge clk); cyc++;
      if (hs) begin
        item++;
        if (item < 4) axi_if.araddr = 32'(item * 4);
        else axi_if.arvalid = 1'b0;
      end
      if (axi_if.rvalid) begin
        chk_cnt++;
        if (axi_if.rdata !== wv[r_cnt]) $display("FAIL b2b_rdata[%0d]: got %h expected %h", r_cnt, axi_if.rdata, wv[r_cnt]);
        else pass_cnt++;
        r_cnt++;
      end
    end
    axi_if.arvalid = 1'b0;
    chk_cnt++;
    if (r_cnt != 4 || cyc != 7) $display("FAIL b2b_read_cycles: %0d responses in %0d cycles expected 4 in 7", r_cnt, cyc);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    int bad = 0;
    @(negedge clk);
    pulse_q.delete();
    axi_if.awvalid = 1'b1; axi_if.awaddr = 32'h4;
    @(negedge clk);
    axi_if.awvalid = 1'b0;
    chk_cnt++;
    if (axi_if.awready !== 1'b0) $display("FAIL midrst_aw_held: awready=%b expected 0", axi_if.awready);
    else pass_cnt++;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({axi_if.awready, axi_if.wready, axi_if.arready, axi_if.bvalid} !== 4'b0000)
      $display("FAIL midrst_in_reset: awready,wready,arready,bvalid=%b expected 0000", {axi_if.awready, axi_if.wready, axi_if.arready, axi_if.bvalid});
    else pass_cnt++;
    rst = 1'b0;
    for (int i = 0; i < N; i++) model[i] = '0;
    @(negedge clk);
    chk_cnt++;
    if ({regs, axi_if.awready} !== {128'h0, 1'b1}) $display("FAIL midrst_release: regs=%h awready=%b expected 0 1", regs, axi_if.awready);
    else pass_cnt++;
    axi_if.wvalid = 1'b1; axi_if.wdata = 32'hFFFFFFFF; axi_if.wstrb = 4'hF;
    @(negedge clk);
    axi_if.wvalid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (axi_if.bvalid !== 1'b0) bad++;
      @(negedge clk);
    end
    chk_cnt++;
    if (bad != 0) $display("FAIL midrst_no_bresp: bvalid seen in %0d cycles expected 0", bad);
    else pass_cnt++;
    chk_cnt++;
    if (regs !== '0 || pulse_q.size() != 0) $display("FAIL midrst_regs: regs=%h pulses=%0d expected 0 0", regs, pulse_q.size());
    else pass_cnt++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    axi_if.awvalid = 1'b0; axi_if.awaddr = '0; axi_if.awprot = 3'b000;
    axi_if.wvalid  = 1'b0; axi_if.wdata  = '0; axi_if.wstrb  = '0;
    axi_if.bready  = 1'b1;
    axi_if.arvalid = 1'b0; axi_if.araddr = '0; axi_if.arprot = 3'b000;
    axi_if.rready  = 1'b1;
    test_reset();
    test_write_read();
    test_strobes();
    test_w_before_aw();
    test_backpressure();
    test_out_of_range();
    test_collision();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/axi4_lite_reg_bank_slv.md
AXI4_LITE_REG_BANK_SLV -- requirements
Module: axi4_lite_reg_bank_slv

Interface
REQ-001 SHALL have parameter AXI4_LITE_ADDR_BIT_WIDTH, default 32: address bus width.
REQ-002 SHALL have parameter AXI4_LITE_DATA_BIT_WIDTH, default 32: data bus width (32 only).
REQ-003 SHALL have parameter NUM_REGS, default 4: register count, power of two, 2..256.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-005 SHALL have port i_sync_rst, input, 1 bit: reset, synchronous to i_clk and active-high.
REQ-006 SHALL have port if_s_axi4_lite, axi4_lite_if slv_port modport: AXI4-Lite responder side.
REQ-007 SHALL have port o_regs, output, NUM_REGS x DATA bits: current register contents.
REQ-008 SHALL have port o_wr_pulse, output, NUM_REGS bits: one-cycle pulse on the index written.

Function
REQ-009 SHALL decode the register index as addr[$clog2(NUM_REGS)+1:2]; addr[1:0] ignored; awprot/arprot ignored.
REQ-010 SHALL treat addr >= NUM_REGS*4 as out of range: writes discarded, reads return 0.
REQ-011 SHALL accept AW and W independently, each into its own one-deep holding buffer; awready/wready SHALL be low while the respective buffer is full.
REQ-012 SHALL commit a write in the first cycle both buffers are full and bvalid is low; it updates only the byte lanes with wstrb=1, frees both buffers, and raises bvalid in the next cycle.
REQ-013 SHALL hold bvalid and bresp stable until bready=1; bvalid SHALL fall in the cycle after the B handshake.
REQ-014 SHALL pulse o_wr_pulse[idx] for exactly one cycle, coincident with the o_regs update, for in-range writes only; wstrb=0 still pulses.
REQ-015 SHALL drive arready high only while rvalid is low; on an AR handshake, rdata/rresp SHALL be registered and rvalid SHALL rise in the next cycle (latency 1).
REQ-016 SHALL hold rvalid, rdata and rresp stable until rready=1; arready SHALL return high in the cycle after the R handshake.
REQ-017 SHALL sample the pre-write value when an AR handshake and a write commit target the same register in one cycle.
REQ-018 SHALL keep the read and write paths fully independent; neither stalls the other.
REQ-019 SHALL give back-to-back sustained throughput of one write per 2 cycles and one read per 2 cycles.

Reset
REQ-020 SHALL, while i_sync_rst=1, clear o_regs, o_wr_pulse, both buffers, bvalid, rvalid, rdata, bresp and rresp to 0, and hold awready, wready and arready low.
REQ-021 SHALL raise awready, wready and arready in the first cycle after i_sync_rst falls.
REQ-022 SHALL discard any in-flight transaction on a reset mid-operation; no B or R response SHALL follow it.

Configuration
REQ-023 SHALL, with AXI4_LITE_REG_BANK_SLV_DECERR_EN defined, return bresp/rresp=DECERR (2'b11) for out-of-range accesses.
REQ-024 SHALL, without AXI4_LITE_REG_BANK_SLV_DECERR_EN, return OKAY (2'b00) for all accesses; out-of-range behaviour otherwise per REQ-010.

Structure
REQ-025 SHALL take axi4_resp_t and the OKAY/SLVERR/DECERR constants from the shared axi4_lite_if_pkg; these SHALL be added there if absent.
REQ-026 SHALL implement the AW and W holding buffers with one sub-module, axi4_lite_1deep_buf (valid/ready in, valid/ready out, parameterised payload width).

Verification
REQ-027 Reset and readback: hold reset 20 cycles, then read 0x0..0xC -> rdata=0, rresp=OKAY, arready high 1 cycle after reset release.
REQ-028 Write-then-read: write 0x12345678, 0x87654321, 0xABCDEF01 and 0x10FEDCBA to 0x0, 0x4, 0x8 and 0xC with wstrb=0xF -> each read returns the written value, o_wr_pulse one-hot for 1 cycle per write.
REQ-029 Byte strobes and ordering: write 0xFFFFFFFF to 0x4, then 0x00000000 with wstrb=0x5 -> readback 0xFF00FF00; a separate write with W presented 3 cycles before AW -> single commit, bvalid 1 cycle after AW handshake.
REQ-030 Backpressure: hold bready=0 and rready=0 for 5 cycles -> bvalid/rvalid, bresp and rdata stable; awready, wready and arready low until release.
REQ-031 Out of range: write 0xDEADBEEF to 0x10, then read 0x10 -> o_regs unchanged, rdata=0, resp=DECERR with macro and OKAY without.
REQ-032 Reset mid-operation and collision: assert reset with AW accepted but W pending -> no bvalid after release, regs=0; AR to 0x8 in the same cycle as a commit of 0x5A5A5A5A to 0x8 -> old value returned.
